// File: rtl/pipe_reg_pkg.sv
// Shared types and constants for the pipe_reg elastic stage.
package pipe_reg_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam int unsigned STALL_CNT_W = 16;

endpackage

// File: rtl/pipe_reg_enabled_reg.sv
// Payload register with synchronous reset and load enable; used for main and skid.
module enabled_reg #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] dataOut
);

  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= RESET_VAL;
    end else if (enable) begin
      r_data <= dataIn;
    end
  end

  assign dataOut = r_data;

endmodule

// File: rtl/pipe_reg.sv
// Elastic two-entry pipeline stage (main + skid) with registered handshakes.
// Optional stall counter enabled by macro PIPE_REG_STALL_CNT_EN.
module pipe_reg
  import pipe_reg_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  input  logic                   flush,
  output logic [STALL_CNT_W-1:0] stall_count
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             w_push;
  logic             w_pop;
  logic             w_main_en;
  logic             w_skid_en;
  logic             w_main_from_skid;
  logic [WIDTH-1:0] w_main_d;
  logic [WIDTH-1:0] w_skid_q;

  assign w_push = in_valid & r_in_ready;
  assign w_pop  = r_out_valid & out_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_main_en        = 1'b0;
    w_skid_en        = 1'b0;
    w_main_from_skid = 1'b0;
    if (flush) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_push) begin
            w_state_nxt = ONE;
            w_main_en   = 1'b1;
          end
        end
        ONE: begin
          if (w_push && w_pop) begin
            w_main_en = 1'b1;
          end else if (w_push) begin
            w_state_nxt = TWO;
            w_skid_en   = 1'b1;
          end else if (w_pop) begin
            w_state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (w_pop) begin
            w_state_nxt      = ONE;
            w_main_en        = 1'b1;
            w_main_from_skid = 1'b1;
          end
        end
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  // Handshake outputs are flops computed from the next state, not decoded from r_state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != TWO);
      r_out_valid <= (w_state_nxt != EMPTY);
    end
  end

  assign w_main_d = w_main_from_skid ? w_skid_q : in_data;

  enabled_reg #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_main (
    .clk     (clk),
    .reset   (reset),
    .enable  (w_main_en),
    .dataIn  (w_main_d),
    .dataOut (out_data)
  );

  enabled_reg #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .enable  (w_skid_en),
    .dataIn  (in_data),
    .dataOut (w_skid_q)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;

`ifdef PIPE_REG_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  // Cleared by reset only; flush leaves the count intact.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (r_out_valid && !out_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_count = r_stall_cnt;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_pipe_reg.sv
// Self-checking bench for pipe_reg: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_pipe_reg;

  localparam logic [31:0] RV   = 32'hDEAD_BEEF;
  localparam logic [4:0]  RV5  = 5'h1F;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, out_ready, flush;
  logic [31:0] in_data;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [15:0] stall_count;

  logic        b_reset, b_in_valid, b_out_ready, b_flush;
  logic [4:0]  b_in_data;
  logic        b_in_ready, b_out_valid;
  logic [4:0]  b_out_data;
  logic [15:0] b_stall_count;

  pipe_reg #(.WIDTH(32), .RESET_VAL(RV)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .flush(flush), .stall_count(stall_count)
  );

  pipe_reg #(.WIDTH(5), .RESET_VAL(RV5)) dut5 (
    .clk(clk), .reset(b_reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .flush(b_flush), .stall_count(b_stall_count)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model: a bounded FIFO of at most two words plus the last head value.
  logic [31:0] q[$];
  logic [31:0] m_head  = RV;
  int unsigned m_stall = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int unsigned sz;
    bit          do_push, do_pop;
    sz = q.size();
    if (reset) begin
      q.delete();
      m_head  = RV;
      m_stall = 0;
    end else begin
`ifdef PIPE_REG_STALL_CNT_EN
      if (sz > 0 && !out_ready && m_stall < 65535) m_stall++;
`endif
      if (flush) begin
        q.delete();
      end else begin
        do_pop  = (sz > 0) && out_ready;
        do_push = in_valid && (sz < 2);
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(in_data);
        if (q.size() > 0) m_head = q[0];
      end
    end
  endtask

  task automatic check_all();
    chk("out_valid", out_valid, (q.size() != 0));
    chk("in_ready", in_ready, (q.size() != 2));
    chk("out_data", out_data, m_head);
    chk("stall_count", stall_count, m_stall);
  endtask

  task automatic cycle(input bit do_chk);
    @(posedge clk);
    model_step();
    #1;
    if (do_chk) check_all();
  endtask

  task automatic drive(input logic r, input logic v, input logic [31:0] d,
                       input logic ordy, input logic fl);
    reset = r; in_valid = v; in_data = d; out_ready = ordy; flush = fl;
  endtask

  initial begin
    logic [31:0] words[100];
    int unsigned nout, nready_low;

    drive(1, 0, '0, 0, 0);
    b_reset = 1; b_in_valid = 0; b_in_data = '0; b_out_ready = 0; b_flush = 0;

    // Reset state
    cycle(1); cycle(1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_data", out_data, RV);
    chk("rst_stall", stall_count, 16'h0);

    // Single push into an empty stage: visible one cycle later
    drive(0, 1, 32'hA5, 1, 0);
    cycle(1);
    chk("a5_valid", out_valid, 1'b1);
    chk("a5_data", out_data, 32'hA5);
    chk("a5_ready", in_ready, 1'b1);
    drive(0, 0, '0, 1, 0);
    cycle(1);

    // Back-pressure: third word refused until the skid drains
    drive(0, 1, 32'h11, 0, 0); cycle(1);
    drive(0, 1, 32'h22, 0, 0); cycle(1);
    chk("bp_ready_after2", in_ready, 1'b0);
    drive(0, 1, 32'h33, 0, 0); cycle(1);
    chk("bp_head_held", out_data, 32'h11);
    drive(0, 1, 32'h33, 1, 0); cycle(1);
    chk("bp_out2", out_data, 32'h22);
    cycle(1);
    chk("bp_out3", out_data, 32'h33);
    drive(0, 0, '0, 1, 0); cycle(1);
    chk("bp_drained", out_valid, 1'b0);

    // 100-word stream at full rate
    nout = 0; nready_low = 0;
    for (int i = 0; i < 100; i++) words[i] = $urandom;
    for (int i = 0; i < 100; i++) begin
      drive(0, 1, words[i], 1, 0);
      cycle(1);
      if (!in_ready) nready_low++;
      if (out_valid) nout++;
      chk("stream_word", out_data, words[i]);
    end
    drive(0, 0, '0, 1, 0);
    cycle(1);
    if (out_valid) nout++;
    chk("stream_count", nout, 100);
    chk("stream_ready_low", nready_low, 0);
    chk("stream_empty", out_valid, 1'b0);

    // Flush in state TWO with a simultaneous push
    drive(0, 1, 32'h44, 0, 0); cycle(1);
    drive(0, 1, 32'h55, 0, 0); cycle(1);
    drive(0, 1, 32'h77, 0, 1); cycle(1);
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_ready", in_ready, 1'b1);
    drive(0, 0, '0, 1, 0); cycle(1);
    chk("flush_not_captured", out_valid, 1'b0);

    // Randomized traffic with occasional flush and reset
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 63) == 0), $urandom_range(0, 1), $urandom,
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
      cycle(1);
    end

    // Reset while holding two entries
    drive(0, 1, 32'h01, 0, 0); cycle(1);
    drive(0, 1, 32'h02, 0, 0); cycle(1);
    chk("two_ready", in_ready, 1'b0);
    drive(1, 1, 32'h03, 1, 0); cycle(1);
    drive(0, 0, '0, 0, 0); cycle(1);
    chk("rst_two_ready", in_ready, 1'b1);
    chk("rst_two_valid", out_valid, 1'b0);

    // Narrow instance: reset in state TWO restores RESET_VAL
    b_reset = 1; cycle(1);
    b_reset = 0; b_in_valid = 1; b_in_data = 5'h03; cycle(1);
    b_in_data = 5'h07; cycle(1);
    chk("w5_two_ready", b_in_ready, 1'b0);
    chk("w5_head", b_out_data, 5'h03);
    b_reset = 1; cycle(1);
    chk("w5_rst_data", b_out_data, RV5);
    chk("w5_rst_valid", b_out_valid, 1'b0);
    b_reset = 0; b_in_valid = 0; cycle(1);
    chk("w5_rel_ready", b_in_ready, 1'b1);

    // Long stall: counter saturates when enabled, stays zero otherwise
    drive(1, 0, '0, 0, 0); cycle(1);
    drive(0, 1, 32'hC0FFEE, 0, 0); cycle(1);
    drive(0, 0, '0, 0, 0);
    for (int i = 0; i < 70000; i++) cycle(0);
    check_all();
`ifdef PIPE_REG_STALL_CNT_EN
    chk("stall_sat", stall_count, 16'hFFFF);
`else
    chk("stall_off", stall_count, 16'h0);
`endif
    drive(0, 0, '0, 0, 1); cycle(1);
    drive(0, 0, '0, 0, 0); cycle(1);
    drive(1, 0, '0, 0, 0); cycle(1);
    chk("stall_rst", stall_count, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_reg.md
PIPE_REG -- requirements
Module: pipe_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload width in bits (legal 1..64).
REQ-002 SHALL have parameter RESET_VAL, default 0, value of out_data after reset (WIDTH bits).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream offers in_data this cycle.
REQ-006 SHALL have port in_ready  output  1  stage accepts a transfer this cycle; driven directly from a flop.
REQ-007 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-008 SHALL have port out_valid  output  1  out_data holds a valid entry.
REQ-009 SHALL have port out_ready  input  1  downstream consumes the entry this cycle.
REQ-010 SHALL have port out_data  output  WIDTH  head payload, registered.
REQ-011 SHALL have port flush  input  1  discard all held entries.
REQ-012 SHALL have port stall_count  output  16  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-013 SHALL form an elastic two-entry stage (main + skid) with states EMPTY, ONE, TWO.
REQ-014 SHALL define push = in_valid & in_ready and pop = out_valid & out_ready.
REQ-015 SHALL drive in_ready = (state != TWO) and out_valid = (state != EMPTY).
REQ-016 SHALL transition EMPTY --push--> ONE, with main loaded from in_data.
REQ-017 SHALL in ONE: push&pop -> ONE with main=in_data; push only -> TWO with skid=in_data; pop only -> EMPTY; neither -> ONE.
REQ-018 SHALL in TWO: pop -> ONE with main=skid; no pop -> TWO, all contents held.
REQ-019 SHALL give latency of exactly one cycle from push to out_valid when the stage is EMPTY.
REQ-020 SHALL sustain one transfer per cycle while out_ready=1 continuously.
REQ-021 SHALL preserve order; no entry dropped or duplicated, except under flush.
REQ-022 SHALL, on flush=1, go to EMPTY next cycle; flush takes priority over a same-cycle push or pop; payload flops keep their values.
REQ-023 SHALL keep out_data unchanged while out_valid=1 and out_ready=0.

Reset
REQ-024 SHALL, with reset=1 at a clock edge, set state EMPTY, out_valid 0, in_ready 1, out_data RESET_VAL, skid RESET_VAL, and stall_count 0.
REQ-025 SHALL discard any handshake in a cycle where reset=1; reset takes priority over flush.
REQ-026 SHALL, on reset mid-operation in state TWO, lose both entries; in_ready reads 1 in the first cycle after release.

Configuration
REQ-027 SHALL gate stall counting with macro PIPE_REG_STALL_CNT_EN.
REQ-028 SHALL, with PIPE_REG_STALL_CNT_EN defined, increment stall_count by 1 each stall cycle, saturate at 16'hFFFF, and clear it on reset only (not on flush).
REQ-029 SHALL, without PIPE_REG_STALL_CNT_EN, tie stall_count to 0 and synthesise no counter flops.

Structure
REQ-030 SHALL place the state enum typedef (EMPTY, ONE, TWO) and the constant STALL_CNT_W=16 in package pipe_reg_pkg.
REQ-031 SHALL use one sub-module, enabled_reg (parameter WIDTH, RESET_VAL; ports dataIn, dataOut, enable, reset, clk), instantiated for both main and skid.

Verification
REQ-032 SHALL cover: reset, then in_valid=1 in_data=0xA5 out_ready=1 -> out_valid=1, out_data=0xA5 the next cycle; in_ready remains 1.
REQ-033 SHALL cover: out_ready=0 with pushes 0x11, 0x22, 0x33 offered on consecutive cycles -> 0x11 and 0x22 accepted, in_ready=0 after the second push; then out_ready=1 -> outputs 0x11, 0x22, 0x33 in order.
REQ-034 SHALL cover: a 100-word stream with out_ready=1 throughout -> 100 outputs in 101 cycles, in_ready never 0.
REQ-035 SHALL cover: state TWO, then flush=1 together with in_valid=1 -> out_valid=0 next cycle, the new word is not captured, and in_ready=1.
REQ-036 SHALL cover: WIDTH=5, RESET_VAL=5'h1F, reset asserted in state TWO -> out_data=5'h1F and out_valid=0 next cycle.
REQ-037 SHALL cover: with the macro defined, out_valid=1 and out_ready=0 held for 70000 cycles -> stall_count=16'hFFFF; with the macro undefined -> stall_count=0.
